maze_generator: RTL and testbench
=================================

# maze_generator

Maze builder that answers the game-state controller's new-round request. Whenever `game_end` is non-zero (start of game or after a tank win), the block carves a fresh random maze into an internal wall store, then raises `maze_ready` and holds it until the controller returns to in-game (`game_end == 2'b00`). The renderer and collision logic read wall bits through a registered read port, and tank spawn logic reads the latched spawn rows.

## Interface
- `COLS`, 8: maze width in cells, 2..16.
- `ROWS`, 6: maze height in cells, 2..16.
- `SEED`, 16'hACE1: LFSR reset value. A value of 0 is replaced by 16'hACE1.
- Derived: `CW = $clog2(COLS)`, `RW = $clog2(ROWS)`, `N = COLS*ROWS`.

Ports:
- `CLK` in 1: clock.
- `RESET` in 1: reset. Synchronous, active-high, on clock `CLK`.
- `game_end` in 2: round request. Any non-zero value means a maze is requested.
- `rd_x` in CW: read column.
- `rd_y` in RW: read row.
- `rd_walls` out 2: walls of cell (`rd_x`, `rd_y`). Bit [1] is the right wall, bit [0] is the bottom wall, 1 means the wall is present.
- `maze_ready` out 1: maze complete. High only in DONE.
- `tank1_row` out RW: spawn row for tank 1, column 0.
- `tank2_row` out RW: spawn row for tank 2, column `COLS-1`.

## Operation
- LFSR: 16-bit, free-running every cycle in every state, including during a request.
  - Update: `lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}`.
  - Because it always runs, the maze depends on when the request arrives.
- States: IDLE, CARVE, DONE.
- IDLE:
  - `game_end != 0` → CARVE, with the cell counter x=0, y=0.
- CARVE: one cell is written per cycle. Scan order is x fastest, then y, starting at (0,0). The value written to cell (x,y) uses the current `lfsr[0]`:
  - x=COLS-1 and y=ROWS-1: 2'b11.
  - x=COLS-1 only: 2'b10 (bottom open).
  - y=ROWS-1 only: 2'b01 (right open).
  - Otherwise: 2'b01 if `lfsr[0]`, else 2'b10.
  - This is the binary-tree algorithm. It yields a perfect maze with exactly N-1 open passages.
  - On the edge that writes cell N-1, go to DONE. On the same edge latch the spawn rows:
    - `tank1_row` = `r1 >= ROWS ? r1-ROWS : r1`, with `r1 = lfsr[RW-1:0]`.
    - `tank2_row` is computed the same way from `lfsr[8 +: RW]`.
    - One subtraction always suffices, because r < 2·ROWS.
  - If `game_end == 0` during CARVE, abort to IDLE. Partial walls are kept and `maze_ready` is never raised.
- DONE:
  - `maze_ready` = 1.
  - A non-zero change in `game_end` (e.g. 11→01) causes no regeneration.
  - `game_end == 0` → IDLE.
- Outer top and left borders are implicit and are not stored.
- Reads during CARVE return the store's current contents (partially old, partially new).
- RESET, at any time including mid-CARVE:
  - state → IDLE, `maze_ready` = 0.
  - All cells = 2'b11.
  - `tank1_row` = `tank2_row` = 0.
  - `lfsr` ← SEED (or 16'hACE1 if SEED is 0).
  - `rd_walls` = 2'b11.

## Timing
- Request sampled at edge k (IDLE → CARVE).
- Cells 0..N-1 are written at edges k+1..k+N.
- `maze_ready` goes high after edge k+N and stays high while `game_end != 0`.
- Default N = 48: `maze_ready` first samples high at edge k+49.
- `maze_ready` falls after the first edge that samples `game_end == 0`. This is a one-cycle turnaround that matches the controller's in-game entry.
- Read port latency is 1: `rd_walls` at edge t+1 reflects the address at edge t.
  - Read and write of the same cell on the same edge returns the old value.
- The spawn rows change only on the CARVE → DONE edge and on RESET.

## Test plan
1. Reset: RESET for 2 cycles, then scan all 48 addresses. Required: `rd_walls` = 2'b11 everywhere, `maze_ready` = 0, both spawn rows 0.
2. Latency and handshake: assert `game_end` = 11 at edge k and hold.
   - `maze_ready` = 0 through edge k+48 and = 1 from edge k+49.
   - Switch `game_end` to 01: `maze_ready` stays 1 and there is no rewrite.
   - Drive `game_end` = 00 at edge m: `maze_ready` = 0 after edge m.
3. Structure, SEED = 16'h0001, with a bench LFSR model:
   - All 48 cells match the model.
   - (7,y) for y<5 = 10, (x,5) for x<7 = 01, (7,5) = 11.
   - 47 open passages, and BFS from (0,0) reaches all 48 cells.
   - Spawn rows match the model and are < 6.
4. Abort: drop `game_end` to 00 after cell 20 is written.
   - Next edge is IDLE, `maze_ready` never asserts, cells 0..20 hold new values and cells 21..47 hold old values.
   - A re-request restarts at cell 0 and completes in 48 cycles.
5. Reset mid-CARVE (at cell 30): all cells read 11, `maze_ready` = 0, and the LFSR restarts from SEED. A repeat of the same request timing reproduces the identical maze.
6. Back-to-back rounds: 11 → 00 → 10 with requests 100 cycles apart.
   - Two full 48-cycle generations.
   - The mazes differ (LFSR advanced) and both pass the check from scenario 3.

Source files
------------

// File: rtl/maze_generator.sv
// maze_generator: binary-tree maze carver with a registered wall read port and spawn-row latch
// Ports:
//   CLK, RESET            clock and synchronous active-high reset
//   game_end[1:0]         round request, any non-zero value asks for a maze
//   rd_x, rd_y            wall read address (column, row)
//   rd_walls[1:0]         registered walls of the addressed cell, [1]=right, [0]=bottom, 1=present
//   maze_ready            high while a finished maze is held (DONE)
//   tank1_row, tank2_row  spawn rows latched when carving completes
module maze_generator #(
    parameter int          COLS = 8,
    parameter int          ROWS = 6,
    parameter logic [15:0] SEED = 16'hACE1,
    localparam int         CW   = $clog2(COLS),
    localparam int         RW   = $clog2(ROWS)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [1:0]    game_end,
    input  logic [CW-1:0] rd_x,
    input  logic [RW-1:0] rd_y,
    output logic [1:0]    rd_walls,
    output logic          maze_ready,
    output logic [RW-1:0] tank1_row,
    output logic [RW-1:0] tank2_row
);
    // The store covers the full address space so out-of-range reads return the reset value 2'b11
    localparam int          CN        = 1 << CW;
    localparam int          RN        = 1 << RW;
    localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    typedef enum logic [1:0] {IDLE, CARVE, DONE} state_t;
    state_t        state, state_nx;
    logic [15:0]   lfsr;
    logic [CW-1:0] cx;
    logic [RW-1:0] cy;
    logic [1:0]    walls [RN][CN];
    logic          req, last_x, last_y, carve_we, finish;
    logic [1:0]    cell_val;
    // r is below 2*ROWS, so a single conditional subtraction maps it into 0..ROWS-1
    function automatic logic [RW-1:0] fold(input logic [RW-1:0] r);
        return int'(r) >= ROWS ? RW'(int'(r) - ROWS) : r;
    endfunction
    assign req      = game_end != 2'b00;
    assign last_x   = int'(cx) == COLS - 1;
    assign last_y   = int'(cy) == ROWS - 1;
    assign carve_we = state == CARVE && req;
    assign finish   = carve_we && last_x && last_y;
    // Binary tree: every cell opens exactly one of right/bottom, forced at the far edges
    assign cell_val = last_x && last_y ? 2'b11 :
                      last_x           ? 2'b10 :
                      last_y           ? 2'b01 :
                      lfsr[0]          ? 2'b01 : 2'b10;
    always_ff @(posedge CLK)
        state <= RESET ? IDLE : state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = req ? CARVE : IDLE;
            CARVE:   state_nx = !req ? IDLE : finish ? DONE : CARVE;
            DONE:    state_nx = req ? DONE : IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_comb
        maze_ready = state == DONE;
    always_ff @(posedge CLK) begin
        if (RESET) begin
            lfsr      <= LFSR_INIT;
            cx        <= '0;
            cy        <= '0;
            tank1_row <= '0;
            tank2_row <= '0;
            rd_walls  <= 2'b11;
            for (int y = 0; y < RN; y++)
                for (int x = 0; x < CN; x++)
                    walls[y][x] <= 2'b11;
        end else begin
            lfsr     <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            cx       <= state != CARVE || last_x ? '0 : cx + 1'b1;
            cy       <= state != CARVE ? '0 : last_x ? cy + 1'b1 : cy;
            rd_walls <= walls[rd_y][rd_x];
            if (carve_we)
                walls[cy][cx] <= cell_val;
            if (finish) begin
                tank1_row <= fold(lfsr[RW-1:0]);
                tank2_row <= fold(lfsr[8 +: RW]);
            end
        end
    end
endmodule

// File: tb/tb_maze_generator.sv
// tb_maze_generator: directed bench for maze_generator with an LFSR reference model
module tb_maze_generator;
    localparam int COLS = 8;
    localparam int ROWS = 6;
    localparam int N    = COLS * ROWS;
    typedef struct {
        logic [1:0] ge;
        int         n;
        logic       exp_ready;
    } vec_t;
    logic           CLK = 1'b0;
    logic           RESET = 1'b1;
    logic [1:0]     game_end = 2'b00;
    logic [2:0]     rd_x = '0;
    logic [2:0]     rd_y = '0;
    logic [1:0]     rd_walls, rd_walls0;
    logic           maze_ready, maze_ready0;
    logic [2:0]     tank1_row, tank2_row, tank1_row0, tank2_row0;
    int             total = 0;
    int             bad = 0;
    logic [15:0]    m_lfsr, m_lfsr0, l0, l00;
    logic [2*N-1:0] got, got0, exp_m, exp_m0, exp_a, prev_m, old_m, new_m;
    logic           seen;
    vec_t           tbl [12];

    always #5 CLK = ~CLK;

    maze_generator #(.COLS(COLS), .ROWS(ROWS), .SEED(16'h0001)) dut (
        .CLK(CLK), .RESET(RESET), .game_end(game_end), .rd_x(rd_x), .rd_y(rd_y),
        .rd_walls(rd_walls), .maze_ready(maze_ready), .tank1_row(tank1_row), .tank2_row(tank2_row)
    );
    maze_generator #(.COLS(COLS), .ROWS(ROWS), .SEED(16'h0000)) dut0 (
        .CLK(CLK), .RESET(RESET), .game_end(game_end), .rd_x(rd_x), .rd_y(rd_y),
        .rd_walls(rd_walls0), .maze_ready(maze_ready0), .tank1_row(tank1_row0), .tank2_row(tank2_row0)
    );

    function automatic logic [15:0] nx(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    always @(posedge CLK) begin
        m_lfsr  <= RESET ? 16'h0001 : nx(m_lfsr);
        m_lfsr0 <= RESET ? 16'hACE1 : nx(m_lfsr0);
    end

    function automatic logic [2*N-1:0] model_maze(input logic [15:0] l);
        logic [2*N-1:0] m;
        int x, y;
        for (int i = 0; i < N; i++) begin
            x = i % COLS;
            y = i / COLS;
            m[2*i +: 2] = (x == COLS-1 && y == ROWS-1) ? 2'b11 :
                          (x == COLS-1) ? 2'b10 :
                          (y == ROWS-1) ? 2'b01 :
                          l[0] ? 2'b01 : 2'b10;
            l = nx(l);
        end
        return m;
    endfunction

    function automatic logic [5:0] model_rows(input logic [15:0] l);
        int r1, r2;
        for (int i = 0; i < N-1; i++) l = nx(l);
        r1 = int'(l[2:0]);
        r2 = int'(l[10:8]);
        r1 = r1 >= ROWS ? r1 - ROWS : r1;
        r2 = r2 >= ROWS ? r2 - ROWS : r2;
        return {3'(r2), 3'(r1)};
    endfunction

    function automatic int open_count(input logic [2*N-1:0] m);
        int c = 0;
        for (int i = 0; i < 2*N; i++) c += m[i] ? 0 : 1;
        return c;
    endfunction

    function automatic int reach_count(input logic [2*N-1:0] m);
        logic [N-1:0] r = '0;
        int c = 0;
        r[0] = 1'b1;
        for (int it = 0; it < N; it++)
            for (int i = 0; i < N; i++) begin
                if (i % COLS != COLS-1 && !m[2*i+1]) begin
                    if (r[i]) r[i+1] = 1'b1;
                    if (r[i+1]) r[i] = 1'b1;
                end
                if (i / COLS != ROWS-1 && !m[2*i]) begin
                    if (r[i]) r[i+COLS] = 1'b1;
                    if (r[i+COLS]) r[i] = 1'b1;
                end
            end
        for (int i = 0; i < N; i++) c += int'(r[i]);
        return c;
    endfunction

    task automatic chk(input string name, input logic [2*N-1:0] act, input logic [2*N-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic scan();
        for (int i = 0; i < N; i++) begin
            rd_x = 3'(i % COLS);
            rd_y = 3'(i / COLS);
            step();
            got[2*i +: 2]  = rd_walls;
            got0[2*i +: 2] = rd_walls0;
        end
    endtask

    task automatic reset_and_scan(input string tag);
        RESET = 1'b1;
        game_end = 2'b00;
        step();
        step();
        RESET = 1'b0;
        chk({tag, "_ready"}, maze_ready, 0);
        scan();
        chk({tag, "_walls"}, got, {2*N{1'b1}});
        chk({tag, "_walls_seed0"}, got0, {2*N{1'b1}});
        chk({tag, "_ready_idle"}, {maze_ready0, maze_ready}, 0);
        chk({tag, "_rows"}, {tank2_row, tank1_row}, 0);
        chk({tag, "_rows_seed0"}, {tank2_row0, tank1_row0}, 0);
    endtask

    // Request sampled at edge k; the LFSR value seen right after edge k carves cell 0
    task automatic gen_round(input logic [1:0] ge);
        game_end = ge;
        step();
        l0  = m_lfsr;
        l00 = m_lfsr0;
        chk("ready_edge_k", maze_ready, 0);
        repeat (N-1) step();
        chk("ready_edge_k47", maze_ready, 0);
        step();
        chk("ready_edge_k48", maze_ready, 1);
        chk("ready_edge_k48_seed0", maze_ready0, 1);
        exp_m  = model_maze(l0);
        exp_m0 = model_maze(l00);
    endtask

    task automatic check_maze(input string tag);
        scan();
        chk({tag, "_maze"}, got, exp_m);
        chk({tag, "_maze_seed0"}, got0, exp_m0);
        for (int y = 0; y < ROWS-1; y++)
            chk($sformatf("%s_right_edge_y%0d", tag, y), got[2*(y*COLS+COLS-1) +: 2], 2'b10);
        for (int x = 0; x < COLS-1; x++)
            chk($sformatf("%s_bottom_edge_x%0d", tag, x), got[2*((ROWS-1)*COLS+x) +: 2], 2'b01);
        chk({tag, "_corner"}, got[2*(N-1) +: 2], 2'b11);
        chk({tag, "_passages"}, open_count(got), N-1);
        chk({tag, "_reach"}, reach_count(got), N);
        chk({tag, "_rows"}, {tank2_row, tank1_row}, model_rows(l0));
        chk({tag, "_rows_seed0"}, {tank2_row0, tank1_row0}, model_rows(l00));
        chk({tag, "_row_range"}, {tank1_row < 3'd6, tank2_row < 3'd6}, 2'b11);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{2'b00, 3,  1'b0};
        tbl[1]  = '{2'b11, 48, 1'b0};
        tbl[2]  = '{2'b11, 1,  1'b1};
        tbl[3]  = '{2'b01, 5,  1'b1};
        tbl[4]  = '{2'b10, 3,  1'b1};
        tbl[5]  = '{2'b00, 1,  1'b0};
        tbl[6]  = '{2'b00, 4,  1'b0};
        tbl[7]  = '{2'b01, 10, 1'b0};
        tbl[8]  = '{2'b00, 1,  1'b0};
        tbl[9]  = '{2'b10, 48, 1'b0};
        tbl[10] = '{2'b10, 1,  1'b1};
        tbl[11] = '{2'b00, 1,  1'b0};

        reset_and_scan("reset");
        gen_round(2'b11);
        check_maze("first");
        exp_a = exp_m;
        game_end = 2'b01;
        repeat (5) step();
        chk("hold_ready_01", maze_ready, 1);
        scan();
        chk("no_rewrite", got, exp_a);
        game_end = 2'b00;
        step();
        chk("ready_fall", maze_ready, 0);

        for (int i = 0; i < 12; i++) begin
            game_end = tbl[i].ge;
            repeat (tbl[i].n) step();
            chk($sformatf("tbl%0d_ready", i), maze_ready, tbl[i].exp_ready);
        end

        gen_round(2'b11);
        check_maze("pre_abort");
        old_m = exp_m;
        game_end = 2'b00;
        step();
        game_end = 2'b11;
        step();
        l0 = m_lfsr;
        seen = maze_ready;
        repeat (21) begin
            step();
            seen |= maze_ready;
        end
        game_end = 2'b00;
        step();
        seen |= maze_ready;
        new_m = model_maze(l0);
        scan();
        seen |= maze_ready;
        chk("abort_no_ready", seen, 0);
        for (int i = 0; i <= 20; i++) old_m[2*i +: 2] = new_m[2*i +: 2];
        chk("abort_partial", got, old_m);
        gen_round(2'b11);
        check_maze("restart");
        game_end = 2'b00;
        step();

        game_end = 2'b11;
        step();
        repeat (30) step();
        reset_and_scan("mid_reset");
        gen_round(2'b11);
        check_maze("after_reset");
        chk("repro", got, exp_a);
        game_end = 2'b00;
        step();

        gen_round(2'b11);
        check_maze("b2b_1");
        prev_m = got;
        game_end = 2'b00;
        repeat (3) step();
        gen_round(2'b10);
        check_maze("b2b_2");
        chk("b2b_differ", got != prev_m, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
